// File: rtl/demux_pkg.sv
// Shared types and constants for the buffered 1-to-4 demultiplexer.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  function automatic logic [NUM_CH-1:0] sel_onehot(sel_t s);
    sel_onehot    = '0;
    sel_onehot[s] = 1'b1;
  endfunction

endpackage

// File: rtl/demux_1to4_buf_if.sv
// Producer/consumer bundle of the 1-to-4 demux: one input stream, four output slots, debug counters.
interface demux_1to4_buf_if
  import demux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_data;
  sel_t                    in_sel;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       out_ready;
  logic [NUM_CH*WIDTH-1:0] out_data;
  logic [NUM_CH*CNT_W-1:0] deliv_cnt;
  logic                    clr_cnt;

  modport master (
    output in_valid, in_data, in_sel, out_ready, clr_cnt,
    input  in_ready, out_valid, out_data, deliv_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready, clr_cnt,
    output in_ready, out_valid, out_data, deliv_cnt
  );

endinterface

// File: rtl/demux_slot.sv
// One single-entry output slot with a saturating delivery counter.
// Load-to-valid 1 cycle; drain and reload in the same cycle keep full throughput.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] cnt
);

  slot_state_t state, state_nxt;
  logic        load;
  logic        drain;

  assign out_valid = (state == FULL);
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt = FULL;
          load      = 1'b1;
        end
      end
      FULL: begin
        // A push while full is only possible when the slot drains this cycle.
        if (drain && push) begin
          load = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      out_data <= '0;
      cnt      <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        out_data <= push_data;
      end
      if (clr_cnt) begin
        cnt <= '0;
      end else if (drain && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_1to4_buf.sv
// Steers one word per cycle into one of four registered slots selected by in_sel.
// Word visible 1 cycle after accept; in_ready drops only when the selected slot is full and not draining.
module demux_1to4_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  demux_1to4_buf_if.slave   bus
);

  logic [NUM_CH-1:0]            vld;
  logic [NUM_CH-1:0]            push;
  logic [NUM_CH-1:0][WIDTH-1:0] dat;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic                         rdy;
  logic                         acc;

  assign rdy  = ~vld[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign acc  = bus.in_valid & rdy;
  assign push = acc ? sel_onehot(bus.in_sel) : '0;

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.out_data  = dat;
  assign bus.deliv_cnt = cnt;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .push      (push[k]),
      .push_data (bus.in_data),
      .out_ready (bus.out_ready[k]),
      .clr_cnt   (bus.clr_cnt),
      .out_valid (vld[k]),
      .out_data  (dat[k]),
      .cnt       (cnt[k])
    );
  end

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Bench for demux_1to4_buf: directed scenarios then random traffic against a one-deep-buffer-per-channel model.
module tb_demux_1to4_buf;
  import demux_pkg::*;

  localparam int W      = 16;
  localparam int CW     = 8;
  localparam int CNTMAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  demux_1to4_buf_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  demux_1to4_buf #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: each channel is a buffer holding at most one word; m_dat keeps the last word loaded.
  bit         m_full [4];
  logic [W-1:0] m_dat [4];
  int         m_cnt  [4];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 1'b0;
      m_dat[k]  = '0;
      m_cnt[k]  = 0;
    end
  endtask

  task automatic check_state(string tag);
    logic [3:0] ev;
    for (int k = 0; k < 4; k++) ev[k] = m_full[k];
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ev));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s.out_data[%0d]", tag, k), 64'(bus.out_data[k*W +: W]), 64'(m_dat[k]));
      check($sformatf("%s.deliv_cnt[%0d]", tag, k), 64'(bus.deliv_cnt[k*CW +: CW]), 64'(m_cnt[k]));
    end
  endtask

  // Called at a falling edge: drive, check in_ready, clock, update model, check state.
  task automatic cycle(bit rst, bit v, sel_t s, logic [W-1:0] d, logic [3:0] ordy, bit clr);
    bit rdy_exp;
    reset         = rst;
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.clr_cnt   = clr;
    rdy_exp = !m_full[s] || ordy[s];
    #1;
    check("in_ready", 64'(bus.in_ready), 64'(rdy_exp));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (m_full[k] && ordy[k]) begin
          m_full[k] = 1'b0;
          if (m_cnt[k] < CNTMAX) m_cnt[k]++;
        end
        if (clr) m_cnt[k] = 0;
      end
      if (v && rdy_exp) begin
        m_full[s] = 1'b1;
        m_dat[s]  = d;
      end
    end
    @(negedge clk);
    check_state("st");
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    bus.clr_cnt   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst.out_valid", 64'(bus.out_valid), 64'h0);
    check("rst.out_data", 64'(bus.out_data), 64'h0);
    check("rst.deliv_cnt", 64'(bus.deliv_cnt), 64'h0);
    for (int s = 0; s < 4; s++) begin
      bus.in_sel = sel_t'(s);
      #1;
      check($sformatf("rst.in_ready[sel=%0d]", s), 64'(bus.in_ready), 64'h1);
    end

    // Single push to channel 2 with consumers stalled
    cycle(1'b0, 1'b1, 2'd2, 16'hA5A5, 4'b0000, 1'b0);
    check("t1.out_valid", 64'(bus.out_valid), 64'h4);
    check("t1.out_data2", 64'(bus.out_data[47:32]), 64'hA5A5);
    bus.in_valid = 1'b0;
    bus.in_sel   = 2'd2;
    #1;
    check("t1.in_ready_sel2", 64'(bus.in_ready), 64'h0);
    bus.in_sel = 2'd0;
    #1;
    check("t1.in_ready_sel0", 64'(bus.in_ready), 64'h1);

    // Back-to-back stream into channel 1 with its consumer always ready
    @(negedge clk);
    cycle(1'b1, 1'b0, 2'd0, '0, 4'b0000, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 1'b1, 2'd1, 16'(i), 4'b0010, 1'b0);
      check($sformatf("t2.out_data1[%0d]", i), 64'(bus.out_data[31:16]), 64'(i));
    end
    cycle(1'b0, 1'b0, 2'd0, '0, 4'b0010, 1'b0);
    check("t2.deliv_cnt1", 64'(bus.deliv_cnt[15:8]), 64'd5);

    // Drain and refill slot 3 in the same cycle
    cycle(1'b0, 1'b1, 2'd3, 16'hBEEF, 4'b0000, 1'b0);
    cycle(1'b0, 1'b1, 2'd3, 16'h1234, 4'b1000, 1'b0);
    check("t3.out_valid3", 64'(bus.out_valid[3]), 64'h1);
    check("t3.out_data3", 64'(bus.out_data[63:48]), 64'h1234);
    check("t3.deliv_cnt3", 64'(bus.deliv_cnt[31:24]), 64'd1);
    cycle(1'b0, 1'b0, 2'd0, '0, 4'b1000, 1'b0);

    // Counter saturation on channel 0, then clear against a simultaneous drain
    cycle(1'b1, 1'b0, 2'd0, '0, 4'b0000, 1'b0);
    for (int i = 0; i < 301; i++) begin
      cycle(1'b0, 1'b1, 2'd0, 16'($urandom), 4'b0001, 1'b0);
    end
    cycle(1'b0, 1'b0, 2'd0, '0, 4'b0001, 1'b0);
    check("t4.deliv_cnt0_sat", 64'(bus.deliv_cnt[7:0]), 64'd255);
    cycle(1'b0, 1'b1, 2'd0, 16'h0F0F, 4'b0000, 1'b0);
    cycle(1'b0, 1'b0, 2'd0, '0, 4'b0001, 1'b1);
    check("t4.deliv_cnt0_clr", 64'(bus.deliv_cnt[7:0]), 64'd0);

    // All slots full, all drain together
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, sel_t'(k), 16'($urandom), 4'b0000, 1'b0);
    end
    check("t5.out_valid_full", 64'(bus.out_valid), 64'hF);
    cycle(1'b0, 1'b0, 2'd0, '0, 4'b1111, 1'b0);
    check("t5.out_valid_empty", 64'(bus.out_valid), 64'h0);
    check("t5.deliv_cnt", 64'(bus.deliv_cnt), 64'h01010101);

    // Reset beats pending slots and a simultaneous push
    cycle(1'b0, 1'b1, 2'd0, 16'h1111, 4'b0000, 1'b0);
    cycle(1'b0, 1'b1, 2'd2, 16'h2222, 4'b0000, 1'b0);
    cycle(1'b1, 1'b1, 2'd1, 16'hDEAD, 4'b0000, 1'b0);
    check("t6.out_valid", 64'(bus.out_valid), 64'h0);
    check("t6.out_data", 64'(bus.out_data), 64'h0);
    check("t6.deliv_cnt", 64'(bus.deliv_cnt), 64'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 3) != 0,
            sel_t'($urandom_range(0, 3)),
            16'($urandom),
            4'($urandom_range(0, 15)),
            $urandom_range(0, 63) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_1to4_buf.md
# demux_1to4_buf

Buffered 1-to-4 demultiplexer: accepts one data word per cycle with a 2-bit destination select and steers it into one of four independent single-entry output slots, each with its own valid/ready handshake. It is the dispatch-side counterpart of the 4-to-1 select path in the processor datapath, used to route a single producer (e.g. write-back or decode output) to four consumers. Each channel has a saturating delivery counter for debug.

## Interface
- WIDTH, 16, data word width in bits
- CNT_W, 8, width of each per-channel delivery counter
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  one clock; reset is synchronous and active-high
- in_valid  in  1  producer has a word on in_data/in_sel
- in_ready  out  1  block can accept the word this cycle
- in_data  in  WIDTH  word to route
- in_sel  in  2  destination channel 0..3
- out_valid  out  4  bit k: slot k holds a word
- out_ready  in  4  bit k: consumer k takes slot k this cycle
- out_data  out  4*WIDTH  slot k data on bits [k*WIDTH +: WIDTH]
- deliv_cnt  out  4*CNT_W  channel k delivered-word count on bits [k*CNT_W +: CNT_W]
- clr_cnt  in  1  synchronous clear of all delivery counters

## Operation
- Accept: acc = in_valid & in_ready. Push to channel s = in_sel.
- in_ready = ~out_valid[in_sel] | out_ready[in_sel]; depends combinationally on in_sel and out_ready, not on in_valid.
- Drain: drain[k] = out_valid[k] & out_ready[k].
- Per-slot FSM, states EMPTY, FULL:
  - EMPTY: push -> FULL, load data. Else stay.
  - FULL: drain & push -> FULL, load new data. Drain only -> EMPTY. Push only cannot occur (in_ready low). Neither -> hold data.
- out_valid[k] = (state k == FULL); out_data slot registered, changes only on load.
- At most one slot is pushed per cycle; any number may drain in the same cycle.
- In-channel order preserved; no ordering guarantee between channels.
- in_valid low: in_sel/in_data ignored; no slot changes except drains.
- Counters: deliv_cnt[k] increments on drain[k], saturates at 2^CNT_W-1 (no wrap). clr_cnt has priority over increment: counter becomes 0 that cycle.
- Reset: all slots EMPTY, out_valid = 4'b0000, out_data = 0, deliv_cnt = 0. Reset wins over any simultaneous push/drain; a word offered in the reset cycle is dropped and not counted.

## Timing
- Latency in_valid/accept -> out_valid[s]: 1 cycle (word visible the cycle after acceptance).
- Throughput: 1 word/cycle to any channel, including back-to-back to the same channel when its consumer holds out_ready high.
- Counter value reflects drains up to the previous edge (1-cycle lag).
- in_ready is combinational within the cycle; no registered-ready bubble.
- Reset value of in_ready follows from state: after reset, in_ready = 1 for any in_sel.

## Structure
- Package demux_pkg: NUM_CH = 4, SEL_W = 2, typedef sel_t (logic [1:0]), enum slot_state_t {EMPTY, FULL}.
- Sub-module demux_slot (one EMPTY/FULL slot + data register + saturating counter, ports clk, reset, push, push_data, out_ready, clr_cnt, out_valid, out_data, cnt), instantiated NUM_CH times by generate loop; top holds select decode and in_ready mux.

## Test plan
- Reset then in_valid=1, in_sel=2, in_data=16'hA5A5, out_ready=0 -> next cycle out_valid=4'b0100, out_data[47:32]=16'hA5A5; in_ready=0 while in_sel=2, in_ready=1 for in_sel=0.
- Channel 1 with out_ready[1]=1, push 16'h0001..16'h0005 on 5 consecutive cycles -> in_ready stays 1, words appear in order one per cycle, deliv_cnt[1]=5 after last drain.
- Slot 3 FULL, out_ready[3]=1 and push 16'h1234 to ch 3 same cycle -> slot stays FULL with 16'h1234, old word counted once.
- CNT_W=8, drain channel 0 300 times -> deliv_cnt[0]=255; assert clr_cnt with simultaneous drain -> 0.
- All four slots FULL, out_ready=4'b1111 one cycle, no push -> out_valid=4'b0000, each counter +1.
- Reset asserted while slots 0 and 2 FULL and a push to ch 1 offered -> next cycle out_valid=0, out_data=0, counters 0, pushed word absent.
